// File: rtl/mic_volume_meter.sv
// Microphone volume front end: syncs the slow sample tick, tracks peak amplitude
// per fixed window and publishes peak, 0..15 level and a decaying peak-hold level.
module mic_volume_meter #(
    parameter int unsigned WINDOW_SAMPLES = 1000,
    parameter int unsigned BASELINE       = 2048,
    parameter int unsigned LEVEL_SHIFT    = 7,
    parameter int unsigned DECAY_WINDOWS  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_tick,
    input  logic [11:0] sample,
    input  logic        clear,
    output logic [11:0] window_peak,
    output logic [3:0]  level,
    output logic [3:0]  hold_level,
    output logic        level_valid
);

    localparam int unsigned SAMPLE_W = 12;
    localparam int unsigned LEVEL_W  = 4;
    localparam int unsigned CNT_W    = $clog2(WINDOW_SAMPLES);
    localparam int unsigned DEC_W    = (DECAY_WINDOWS > 1) ? $clog2(DECAY_WINDOWS) : 1;

    localparam logic [SAMPLE_W-1:0] BASE_CODE = SAMPLE_W'(BASELINE);
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(WINDOW_SAMPLES - 1);
    localparam logic [DEC_W-1:0]    DEC_LAST  = DEC_W'(DECAY_WINDOWS - 1);
    localparam logic [LEVEL_W-1:0]  LEVEL_MAX = LEVEL_W'(15);

    // Tick synchroniser and edge history
    logic sync1_q, sync2_q, hist_q;

    // Window and hold state
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SAMPLE_W-1:0] run_max_q, run_max_d;
    logic [DEC_W-1:0]    decay_q, decay_d;

    // Published outputs
    logic [SAMPLE_W-1:0] peak_q, peak_d;
    logic [LEVEL_W-1:0]  level_q, level_d;
    logic [LEVEL_W-1:0]  hold_q, hold_d;
    logic                valid_q, valid_d;

    // Datapath
    logic                tick_edge_c;
    logic                win_done_c;
    logic [SAMPLE_W-1:0] amp_c;
    logic [SAMPLE_W-1:0] new_max_c;
    logic [SAMPLE_W-1:0] shifted_c;
    logic [LEVEL_W-1:0]  level_new_c;

    // A clear drops any sample whose edge lands in the same cycle
    assign tick_edge_c = sync2_q & ~hist_q & ~clear;
    assign win_done_c  = tick_edge_c && (cnt_q == CNT_LAST);
    assign amp_c       = (sample > BASE_CODE) ? (sample - BASE_CODE) : '0;
    assign new_max_c   = (amp_c > run_max_q) ? amp_c : run_max_q;
    assign shifted_c   = new_max_c >> LEVEL_SHIFT;
    assign level_new_c = (shifted_c > SAMPLE_W'(15)) ? LEVEL_MAX : shifted_c[LEVEL_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= sample_tick;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            run_max_q <= '0;
            decay_q   <= '0;
            peak_q    <= '0;
            level_q   <= '0;
            hold_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            run_max_q <= run_max_d;
            decay_q   <= decay_d;
            peak_q    <= peak_d;
            level_q   <= level_d;
            hold_q    <= hold_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        run_max_d = run_max_q;
        decay_d   = decay_q;
        peak_d    = peak_q;
        level_d   = level_q;
        hold_d    = hold_q;
        valid_d   = 1'b0;

        if (clear) begin
            cnt_d     = '0;
            run_max_d = '0;
            decay_d   = '0;
        end else if (win_done_c) begin
            peak_d    = new_max_c;
            level_d   = level_new_c;
            run_max_d = '0;
            cnt_d     = '0;
            valid_d   = 1'b1;
            // Hold tracks rises at once, falls one step per DECAY_WINDOWS quiet windows
            if (level_new_c >= hold_q) begin
                hold_d  = level_new_c;
                decay_d = '0;
            end else if (decay_q == DEC_LAST) begin
                hold_d  = hold_q - LEVEL_W'(1);
                decay_d = '0;
            end else begin
                decay_d = decay_q + DEC_W'(1);
            end
        end else if (tick_edge_c) begin
            run_max_d = new_max_c;
            cnt_d     = cnt_q + CNT_W'(1);
        end
    end

    assign window_peak = peak_q;
    assign level       = level_q;
    assign hold_level  = hold_q;
    assign level_valid = valid_q;

endmodule

// File: tb/tb_mic_volume_meter.sv
// Directed self-checking bench for mic_volume_meter with a 4-sample window
// and 2-window hold decay.
module tb_mic_volume_meter;

    logic        clk;
    logic        rst_n;
    logic        sample_tick;
    logic [11:0] sample;
    logic        clear;
    logic [11:0] window_peak;
    logic [3:0]  level;
    logic [3:0]  hold_level;
    logic        level_valid;

    int errors = 0;
    int checks = 0;

    mic_volume_meter #(
        .WINDOW_SAMPLES(4),
        .BASELINE      (2048),
        .LEVEL_SHIFT   (7),
        .DECAY_WINDOWS (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_tick(sample_tick),
        .sample     (sample),
        .clear      (clear),
        .window_peak(window_peak),
        .level      (level),
        .hold_level (hold_level),
        .level_valid(level_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One tick period: high 4 clk, low 4 clk; counts level_valid pulses
    task automatic do_sample(input string tag, input logic [11:0] v, input int exp_pulses);
        int pulses = 0;
        int at = -1;
        @(negedge clk);
        sample      = v;
        sample_tick = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (level_valid === 1'b1) begin
                pulses++;
                if (at < 0) at = i;
            end
            if (i == 4) begin
                @(negedge clk);
                sample_tick = 1'b0;
            end
        end
        chk({tag, "_pulses"}, pulses, exp_pulses);
        if (exp_pulses > 0) chk({tag, "_pulse_edge"}, at, 3);
    endtask

    task automatic chk_outputs(input string tag, input int pk, input int lv, input int hd);
        chk({tag, "_peak"}, 32'(window_peak), pk);
        chk({tag, "_level"}, 32'(level), lv);
        chk({tag, "_hold"}, 32'(hold_level), hd);
    endtask

    initial begin
        int pulses;
        rst_n       = 1'b0;
        sample_tick = 1'b0;
        sample      = 12'd0;
        clear       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs("reset", 0, 0, 0);
        chk("reset_valid", 32'(level_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic window
        do_sample("w1s1", 12'd2048, 0);
        do_sample("w1s2", 12'd2100, 0);
        do_sample("w1s3", 12'd3000, 0);
        do_sample("w1s4", 12'd2500, 1);
        chk_outputs("w1", 952, 7, 7);

        // Samples at or below baseline give zero amplitude
        do_sample("w2s1", 12'd1000, 0);
        do_sample("w2s2", 12'd0, 0);
        do_sample("w2s3", 12'd2048, 0);
        do_sample("w2s4", 12'd2040, 1);
        chk_outputs("w2", 0, 0, 7);

        // Full scale saturates level
        for (int s = 0; s < 4; s++) do_sample("w3", 12'd4095, (s == 3) ? 1 : 0);
        chk_outputs("w3", 2047, 15, 15);

        // Decay: 15,14,14,13,13,... down to 0, then stays at 0
        for (int k = 1; k <= 32; k++) begin
            for (int s = 0; s < 4; s++) do_sample("decay", 12'd2048, (s == 3) ? 1 : 0);
            chk("decay_hold", 32'(hold_level), (k >= 30) ? 0 : 15 - k / 2);
        end
        chk("decay_level", 32'(level), 0);

        // Level-9 window restores hold
        for (int s = 0; s < 4; s++) do_sample("w9", 12'd3248, (s == 3) ? 1 : 0);
        chk_outputs("w9", 1200, 9, 9);

        // Clear coincident with the third sample edge
        do_sample("clr_s1", 12'd3000, 0);
        do_sample("clr_s2", 12'd3000, 0);
        pulses = 0;
        @(negedge clk);
        sample      = 12'd3000;
        sample_tick = 1'b1;
        clear       = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (level_valid === 1'b1) pulses++;
        end
        @(negedge clk);
        clear       = 1'b0;
        sample_tick = 1'b0;
        repeat (4) @(posedge clk);
        chk("clr_pulses", pulses, 0);
        chk_outputs("clr_hold", 1200, 9, 9);
        do_sample("clr_w_s1", 12'd2200, 0);
        do_sample("clr_w_s2", 12'd2200, 0);
        do_sample("clr_w_s3", 12'd2200, 0);
        do_sample("clr_w_s4", 12'd2200, 1);
        chk_outputs("clr_w", 152, 1, 9);

        // Tick held high for 100 clk counts once
        pulses = 0;
        @(negedge clk);
        sample      = 12'd2100;
        sample_tick = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (level_valid === 1'b1) pulses++;
        end
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (4) @(posedge clk);
        chk("long_tick_pulses", pulses, 0);
        do_sample("long_s2", 12'd2048, 0);
        do_sample("long_s3", 12'd2048, 0);
        do_sample("long_s4", 12'd2048, 1);
        chk_outputs("long", 52, 0, 8);

        // Async reset mid-window discards the partial window
        do_sample("rst_s1", 12'd3000, 0);
        do_sample("rst_s2", 12'd3000, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_outputs("async_rst", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 1; s <= 7; s++) do_sample("post_rst", 12'd2148, (s == 4) ? 1 : 0);
        chk_outputs("post_rst", 100, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
